// File: rtl/kgp_ctrl_pkg.sv
// Shared control encodings for the PC sequencer: instruction classes, PC select codes,
// FSM states and the registered control-output bundle.
package kgp_ctrl_pkg;

   localparam int unsigned CLASS_W  = 3;
   localparam int unsigned PC_SRC_W = 2;
   localparam int unsigned STATE_W  = 3;

   typedef enum logic [CLASS_W-1:0] {
      IC_ALU     = 3'd0,
      IC_LOAD    = 3'd1,
      IC_STORE   = 3'd2,
      IC_BRANCH  = 3'd3,
      IC_JUMP    = 3'd4,
      IC_JR      = 3'd5,
      IC_HALT    = 3'd6,
      IC_ILLEGAL = 3'd7
   } instr_class_e;

   typedef enum logic [PC_SRC_W-1:0] {
      PC_INC = 2'b00,
      PC_REG = 2'b01,
      PC_BR  = 2'b10,
      PC_JMP = 2'b11
   } pc_src_e;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_FAULT  = 3'd6
   } state_e;

   typedef struct packed {
      logic    imem_req;
      logic    ir_load;
      logic    dmem_req;
      logic    dmem_we;
      logic    reg_write;
      logic    pc_write;
      pc_src_e pc_src;
      logic    halted;
      logic    fault;
   } ctrl_out_t;

   function automatic logic is_mem_class(input instr_class_e c);
      return (c == IC_LOAD) || (c == IC_STORE);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/memory/datapath-facing signal bundle of the PC sequencer.
interface pc_sequencer_if #(parameter int unsigned CNT_W = 32);
   import kgp_ctrl_pkg::*;

   logic [CLASS_W-1:0]  instr_class;
   logic                zero;
   logic                imem_ready;
   logic                dmem_ready;
   logic                resume;
   logic                imem_req;
   logic                ir_load;
   logic                dmem_req;
   logic                dmem_we;
   logic                reg_write;
   logic                pc_write;
   logic [PC_SRC_W-1:0] pc_src;
   logic                halted;
   logic                fault;
   logic [CNT_W-1:0]    retired;

   modport master (
      input  instr_class, zero, imem_ready, dmem_ready, resume,
      output imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, pc_src,
             halted, fault, retired
   );

   modport slave (
      output instr_class, zero, imem_ready, dmem_ready, resume,
      input  imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, pc_src,
             halted, fault, retired
   );

endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait-cycle counter; o_expired_c flags the TIMEOUT-th waiting cycle.
module seq_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired_c
);

   localparam int unsigned W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_count) r_cnt <= r_cnt + W'(1);
   end

   assign o_expired_c = (r_cnt == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM sequencing fetch, decode, execute, memory and write-back;
// every output is registered from the next-state decode.
module pc_sequencer
   import kgp_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   state_e           r_state, w_next;
   instr_class_e     r_class;
   ctrl_out_t        r_out, w_out;
   logic [CNT_W-1:0] r_retired;
   logic             w_count, w_clear, w_expired;

   seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_count    (w_count),
      .o_expired_c(w_expired)
   );

   assign w_clear = (w_next != r_state);

   always_comb begin
      w_next  = r_state;
      w_out   = '0;
      w_count = 1'b0;
      case (r_state)
         // Right after reset imem_req is still low, so ready is not yet accepted.
         ST_FETCH: begin
            if (r_out.imem_req) begin
               if (bus.imem_ready)  w_next  = ST_DECODE;
               else if (w_expired)  w_next  = ST_FAULT;
               else                 w_count = 1'b1;
            end
         end
         ST_DECODE: begin
            case (instr_class_e'(bus.instr_class))
               IC_HALT:    w_next = ST_HALT;
               IC_ILLEGAL: w_next = ST_FAULT;
               default:    w_next = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            if (r_class == IC_ALU)           w_next = ST_WB;
            else if (is_mem_class(r_class))  w_next = ST_MEM;
            else begin
               w_next         = ST_FETCH;
               w_out.pc_write = 1'b1;
               case (r_class)
                  IC_BRANCH: w_out.pc_src = bus.zero ? PC_BR : PC_INC;
                  IC_JUMP:   w_out.pc_src = PC_JMP;
                  IC_JR:     w_out.pc_src = PC_REG;
                  default: begin
                     w_next         = ST_FAULT;
                     w_out.pc_write = 1'b0;
                  end
               endcase
            end
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               if (r_class == IC_STORE) begin
                  w_next         = ST_FETCH;
                  w_out.pc_write = 1'b1;
               end else begin
                  w_next = ST_WB;
               end
            end else if (w_expired) begin
               w_next = ST_FAULT;
            end else begin
               w_count = 1'b1;
            end
         end
         ST_WB:   w_next = ST_FETCH;
         ST_HALT: if (bus.resume) w_next = ST_FETCH;
         default: w_next = ST_FAULT;
      endcase

      // Moore decode of the state being entered
      w_out.imem_req  = (w_next == ST_FETCH);
      w_out.ir_load   = (w_next == ST_DECODE);
      w_out.dmem_req  = (w_next == ST_MEM);
      w_out.dmem_we   = (w_next == ST_MEM) && (r_class == IC_STORE);
      w_out.reg_write = (w_next == ST_WB);
      w_out.pc_write  = w_out.pc_write | (w_next == ST_WB);
      w_out.halted    = (w_next == ST_HALT);
      w_out.fault     = (w_next == ST_FAULT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_FETCH;
         r_class   <= IC_ALU;
         r_out     <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_out   <= w_out;
         if (r_state == ST_DECODE) r_class <= instr_class_e'(bus.instr_class);
         if (w_out.pc_write)       r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign bus.imem_req  = r_out.imem_req;
   assign bus.ir_load   = r_out.ir_load;
   assign bus.dmem_req  = r_out.dmem_req;
   assign bus.dmem_we   = r_out.dmem_we;
   assign bus.reg_write = r_out.reg_write;
   assign bus.pc_write  = r_out.pc_write;
   assign bus.pc_src    = r_out.pc_src;
   assign bus.halted    = r_out.halted;
   assign bus.fault     = r_out.fault;
   assign bus.retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: instruction-level timeline model expanded into expected per-cycle outputs.
module tb_pc_sequencer;
   import kgp_ctrl_pkg::*;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CNT_W   = 32;

   localparam logic [9:0] B_IREQ = 10'b10_0000_0000;
   localparam logic [9:0] B_IRL  = 10'b01_0000_0000;
   localparam logic [9:0] B_DREQ = 10'b00_1000_0000;
   localparam logic [9:0] B_DWE  = 10'b00_0100_0000;
   localparam logic [9:0] B_RW   = 10'b00_0010_0000;
   localparam logic [9:0] B_PCW  = 10'b00_0001_0000;
   localparam logic [9:0] B_HALT = 10'b00_0000_0010;
   localparam logic [9:0] B_FLT  = 10'b00_0000_0001;

   typedef struct {
      logic [2:0] cls;
      logic       z;
      logic       ir;
      logic       dr;
      logic       res;
      logic [9:0] exp;
   } rec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   rec_t             q[$];
   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   logic [CNT_W-1:0] exp_ret;
   logic             pend_pcw;
   logic [1:0]       pend_src;

   pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

   pc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] src_bits(input logic [1:0] s);
      return {6'b0, s, 2'b0};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [2:0] rc();
      return 3'($urandom);
   endfunction

   function automatic logic [9:0] observe();
      return {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.reg_write,
              bus.pc_write, bus.pc_src, bus.halted, bus.fault};
   endfunction

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, got, want);
      end
   endtask

   task automatic check_ret(input string tag, input logic [CNT_W-1:0] want);
      total++;
      assert (bus.retired === want) else begin
         bad++;
         $error("FAIL %s cycle=%0d retired got=%0d want=%0d", tag, cyc, bus.retired, want);
      end
   endtask

   task automatic push(input logic [9:0] e, input logic ir, input logic dr,
                       input logic [2:0] cls, input logic z, input logic res);
      rec_t r;
      r.exp = e; r.ir = ir; r.dr = dr; r.cls = cls; r.z = z; r.res = res;
      q.push_back(r);
   endtask

   // Fetch lasts iw+1 cycles; a PC update left over from the previous instruction lands in its first cycle.
   task automatic add_fetch(input int iw, input logic never);
      logic [9:0] e;
      for (int k = 0; k <= iw; k++) begin
         e = B_IREQ;
         if (k == 0 && pend_pcw) e = e | B_PCW | src_bits(pend_src);
         push(e, (k == iw) && !never, rb(), rc(), rb(), rb());
      end
      pend_pcw = 1'b0;
      pend_src = 2'b00;
   endtask

   task automatic add_fault(input int n);
      for (int k = 0; k < n; k++) push(B_FLT, rb(), rb(), rc(), rb(), (k % 2) == 0);
   endtask

   task automatic add_instr(input logic [2:0] cls, input logic z, input int iw, input int dw, input int hw);
      add_fetch(iw, 1'b0);
      push(B_IRL, rb(), rb(), cls, rb(), rb());
      if (cls == IC_HALT) begin
         for (int k = 0; k < hw; k++) push(B_HALT, rb(), rb(), rc(), rb(), k == hw - 1);
         return;
      end
      if (cls == IC_ILLEGAL) begin
         add_fault(5);
         return;
      end
      push(10'b0, rb(), rb(), rc(), z, rb());
      case (cls)
         IC_ALU: push(B_RW | B_PCW | src_bits(PC_INC), rb(), rb(), rc(), rb(), rb());
         IC_LOAD, IC_STORE: begin
            for (int k = 0; k <= dw; k++)
               push(B_DREQ | ((cls == IC_STORE) ? B_DWE : 10'b0), rb(), k == dw, rc(), rb(), rb());
            if (cls == IC_LOAD) push(B_RW | B_PCW | src_bits(PC_INC), rb(), rb(), rc(), rb(), rb());
            else begin pend_pcw = 1'b1; pend_src = PC_INC; end
         end
         IC_BRANCH: begin pend_pcw = 1'b1; pend_src = z ? PC_BR : PC_INC; end
         IC_JUMP:   begin pend_pcw = 1'b1; pend_src = PC_JMP; end
         default:   begin pend_pcw = 1'b1; pend_src = PC_REG; end
      endcase
   endtask

   task automatic play_n(input int n);
      rec_t r;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         r = q.pop_front();
         @(posedge clk);
         #1;
         cyc++;
         bus.instr_class = r.cls;
         bus.zero        = r.z;
         bus.imem_ready  = r.ir;
         bus.dmem_ready  = r.dr;
         bus.resume      = r.res;
         if (r.exp[4]) exp_ret++;
         check("outs", observe(), r.exp);
         check_ret("retired", exp_ret);
      end
   endtask

   task automatic play_all();
      play_n(q.size());
   endtask

   task automatic do_reset();
      reset           = 1'b0;
      bus.instr_class = 3'd0;
      bus.zero        = 1'b0;
      bus.imem_ready  = 1'b0;
      bus.dmem_ready  = 1'b0;
      bus.resume      = 1'b0;
      #1;
      check("rst_async", observe(), 10'b0);
      check_ret("rst_async_ret", 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_release", observe(), 10'b0);
      check_ret("rst_release_ret", 32'd0);
      exp_ret  = '0;
      pend_pcw = 1'b0;
      pend_src = 2'b00;
      q.delete();
   endtask

   initial begin
      logic [2:0] c;
      exp_ret  = '0;
      pend_pcw = 1'b0;
      pend_src = 2'b00;
      #2;
      do_reset();

      // four zero-wait ALU instructions
      repeat (4) add_instr(IC_ALU, 1'b0, 0, 0, 0);
      play_all();
      check_ret("alu4_retired", 32'd4);

      add_instr(IC_BRANCH, 1'b1, 0, 0, 0);
      add_instr(IC_BRANCH, 1'b0, 0, 0, 0);
      add_instr(IC_JUMP,   1'b0, 1, 0, 0);
      add_instr(IC_JR,     1'b0, 2, 0, 0);
      add_instr(IC_LOAD,   1'b0, 0, 3, 0);
      add_instr(IC_STORE,  1'b0, 0, 0, 0);
      add_instr(IC_LOAD,   1'b0, 0, 0, 0);
      add_instr(IC_STORE,  1'b0, 1, 2, 0);
      // last acceptable wait cycle before the timeout
      add_instr(IC_ALU,    1'b0, TIMEOUT - 1, 0, 0);
      add_instr(IC_LOAD,   1'b0, 0, TIMEOUT - 1, 0);
      add_instr(IC_STORE,  1'b0, 0, TIMEOUT - 1, 0);
      add_instr(IC_HALT,   1'b0, 0, 0, 10);
      add_instr(IC_ALU,    1'b0, 0, 0, 0);
      play_all();

      repeat (40) begin
         c = 3'($urandom_range(0, 6));
         add_instr(c, rb(), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 4));
      end
      add_instr(IC_ALU, 1'b0, 0, 0, 0);
      play_all();

      // reset while the data access is still waiting
      add_instr(IC_LOAD, 1'b0, 1, 8, 0);
      play_n(7);
      do_reset();
      add_instr(IC_ALU, 1'b0, 0, 0, 0);
      play_all();
      check_ret("after_reset_retired", 32'd1);

      // fetch never answered: fault after TIMEOUT cycles, resume ignored
      add_fetch(TIMEOUT - 1, 1'b1);
      add_fault(6);
      play_all();
      do_reset();

      add_instr(IC_ILLEGAL, 1'b0, 0, 0, 0);
      play_all();
      do_reset();

      add_instr(IC_JUMP, 1'b0, 0, 0, 0);
      add_instr(IC_ALU,  1'b0, 0, 0, 0);
      play_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
